rlock_scoreboard: RTL and testbench
===================================

Name: rlock_scoreboard

Overview:
- Multi-port register-lock scoreboard. It is the parametrised successor of the single-port lock counter.
- Tracks outstanding writers per architectural register with saturating counters.
- Accepts NSET lock requests and NCLR unlock requests per cycle. Exposes a per-register lock vector to issue logic.
- Adds back-pressure on counter saturation, a flush, and a sticky underflow error flag.

Parameters:
- XWDT, 6, register index width.
- XN, 64, number of tracked registers; XN <= 2**XWDT.
- NSET, 2, lock (set) ports per cycle.
- NCLR, 2, unlock (clear) ports per cycle.
- CWDT, 3, per-register counter width; max count CMAX = 2**CWDT-1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- set_valid  in  NSET  per-port lock request.
- set_idx  in  NSET*XWDT  packed register indices; port p occupies bits [p*XWDT +: XWDT].
- set_ready  out  1  combinational; the set group is accepted this cycle.
- clr_valid  in  NCLR  per-port unlock request.
- clr_idx  in  NCLR*XWDT  packed indices, same packing as set_idx.
- flush  in  1  synchronous clear of all counters.
- rlocks  out  XN  registered; bit i = (count[i] != 0).
- err_underflow  out  1  sticky; a clear hit a zero counter.
- err_clear  in  1  clears err_underflow.

Behaviour:
- Reset (rst=1 at an edge):
  - all counters become 0, rlocks=0, err_underflow=0.
  - rst overrides flush, sets and clears in the same cycle.
- Index 0 is hardwired unlocked. Sets and clears to index 0 are ignored and never raise errors; rlocks[0] is always 0.
- Indices >= XN are treated the same as index 0.
- Per-register update each cycle: count[i] <= count[i] + inc[i] - dec[i].
  - inc[i] = number of accepted valid set ports with idx==i. Duplicates count separately: two ports naming reg 5 add 2.
  - dec[i] = number of valid clear ports with idx==i, limited to the current count[i].
  - Compute the sum at CWDT+2 bits; no wrap-around is ever permitted.
- Underflow:
  - Occurs when clears to i exceed count[i]. count[i] saturates at 0 (net of incs still applied).
  - err_underflow <= 1 at that edge.
- Set acceptance (set_ready, combinational from current counts and inputs):
  - set_ready=0 if, for any i, count[i] + inc_requested[i] > CMAX.
  - This check is pessimistic: same-cycle clears are ignored.
  - When set_ready=0, no set port is applied. Clears are still applied.
  - The requester holds set_valid/set_idx until set_ready=1.
  - The set group is all-or-nothing; there is no partial acceptance.
- Simultaneous set and clear to the same register in one cycle: both apply (net delta).
  - Example: count 1, one set + one clear -> count 1, rlocks bit stays 1.
  - Example: count 0, one set + one clear -> underflow rule applies to the clear evaluated against count 0, so count becomes 1 and err_underflow is set.
- rlocks latency: 1 cycle. rlocks reflects counts after the same edge that updated them; no extra stage.
- Flush (flush=1, rst=0):
  - all counters and rlocks become 0 at the edge.
  - same-cycle sets and clears are discarded.
  - err_underflow is unchanged.
  - set_ready is 1 while flush is asserted.
- err_clear=1 clears err_underflow at the edge. A new underflow in the same cycle wins (flag stays 1).
- No $display/$strobe in synthesised paths; debug tracing belongs to the bench.

Decomposition:
- Package rlock_pkg holds:
  - default widths XWDT/XN/CWDT;
  - the function unpacking index slices;
  - the function popcount_match(idx_vec, valid, target) returning the number of matching ports.
- Sub-module rlock_cell (one per register, generated XN-1 times). It takes inc, dec_req, flush and rst, and outputs count_nz, would_overflow and underflow.
- The top level ORs would_overflow into ~set_ready and underflow into the error flag.

Test Plan:
1. Reset: hold rst 2 cycles with set_valid=2'b11 to regs 3, 4 -> rlocks==0, set_ready==1, err_underflow==0 after release.
2. Dual set and duplicate:
   - set ports to {5,5} -> next cycle rlocks[5]=1 (count 2).
   - then two clears to 5 in one cycle -> rlocks[5]=0 the following cycle; one clear leaves it 1.
3. Saturation (CWDT=3):
   - lock reg 7 seven times -> count 7.
   - a further set to {7,9} -> set_ready=0 and reg 9 is not locked.
   - a clear to 7 that cycle drops the count to 6; the next cycle's retry is accepted.
4. Same-cycle set+clear:
   - reg 2 at count 1, set 2 + clear 2 -> rlocks[2] stays 1.
   - reg 8 at count 0, set 8 + clear 8 -> rlocks[8]=1, err_underflow=1.
5. Underflow and error clear:
   - clear reg 10 at count 0 -> err_underflow=1, rlocks[10]=0.
   - err_clear with no new underflow -> flag 0.
   - err_clear together with a new underflow -> flag stays 1.
6. Flush and index 0:
   - lock regs 1, 63 and 0 -> rlocks[0]=0.
   - flush with a simultaneous set to 12 -> rlocks==0 next cycle, err_underflow unchanged.

Source files
------------

// File: rtl/rlock_pkg.sv
// Shared widths and index helpers for the register-lock scoreboard.
// Helpers take fixed maximum-width vectors so any port count/index width fits.
package rlock_pkg;

  localparam int XWDT_DEF = 6;
  localparam int XN_DEF   = 64;
  localparam int CWDT_DEF = 3;
  localparam int NSET_DEF = 2;
  localparam int NCLR_DEF = 2;

  localparam int WMAX = 16;
  localparam int PMAX = 8;
  localparam int VW   = PMAX * WMAX;
  localparam int CNTW = 8;

  // Index of port p when each port occupies w bits.
  function automatic logic [WMAX-1:0] get_idx(input logic [VW-1:0] idx_vec,
                                               input int unsigned p,
                                               input int unsigned w);
    logic [VW-1:0] sh;
    logic [WMAX-1:0] mask;
    sh   = idx_vec >> (p * w);
    mask = (WMAX'(1) << w) - WMAX'(1);
    return sh[WMAX-1:0] & mask;
  endfunction

  // Number of valid ports among the first nports whose index equals target.
  function automatic logic [CNTW-1:0] popcount_match(input logic [VW-1:0]   idx_vec,
                                                     input logic [PMAX-1:0] valid,
                                                     input logic [WMAX-1:0] target,
                                                     input int unsigned     nports,
                                                     input int unsigned     w);
    logic [CNTW-1:0] cnt;
    cnt = '0;
    for (int p = 0; p < PMAX; p++) begin
      if ((p < int'(nports)) && valid[p] && (get_idx(idx_vec, p, w) == target))
        cnt = cnt + CNTW'(1);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/rlock_cell.sv
// One saturating outstanding-writer counter for a single architectural register.
// Clears beyond the current count are clipped and reported as underflow.
module rlock_cell
  import rlock_pkg::*;
#(
  parameter int CWDT = CWDT_DEF,
  parameter int IW   = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          set_accept,
  input  logic [IW-1:0] inc,
  input  logic [IW-1:0] dec_req,
  output logic          count_nz,
  output logic          would_overflow,
  output logic          underflow
);

  localparam int SW   = CWDT + IW + 1;
  localparam int CMAX = (1 << CWDT) - 1;

  logic [CWDT-1:0] count;
  logic [SW-1:0]   inc_app;
  logic [SW-1:0]   dec_eff;
  logic [SW-1:0]   next_sum;

  // Requested incs are checked regardless of acceptance; this drives back-pressure.
  assign would_overflow = (SW'(count) + SW'(inc)) > SW'(CMAX);

  always_comb begin
    inc_app   = set_accept ? SW'(inc) : '0;
    underflow = 1'b0;
    dec_eff   = SW'(dec_req);
    if (SW'(dec_req) > SW'(count)) begin
      dec_eff   = SW'(count);
      underflow = ~flush;
    end
    next_sum = SW'(count) + inc_app - dec_eff;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) count <= '0;
    else              count <= next_sum[CWDT-1:0];
  end

  assign count_nz = (count != '0);

endmodule

// File: rtl/rlock_scoreboard.sv
// Multi-port register-lock scoreboard: per-register writer counters with
// all-or-nothing set acceptance, flush, and a sticky underflow flag.
module rlock_scoreboard
  import rlock_pkg::*;
#(
  parameter int XWDT = XWDT_DEF,
  parameter int XN   = XN_DEF,
  parameter int NSET = NSET_DEF,
  parameter int NCLR = NCLR_DEF,
  parameter int CWDT = CWDT_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NSET-1:0]      set_valid,
  input  logic [NSET*XWDT-1:0] set_idx,
  output logic                 set_ready,
  input  logic [NCLR-1:0]      clr_valid,
  input  logic [NCLR*XWDT-1:0] clr_idx,
  input  logic                 flush,
  output logic [XN-1:0]        rlocks,
  output logic                 err_underflow,
  input  logic                 err_clear
);

  localparam int PMX = (NSET > NCLR) ? NSET : NCLR;
  localparam int IW  = $clog2(PMX + 1);

  logic [VW-1:0]   set_vec;
  logic [VW-1:0]   clr_vec;
  logic [PMAX-1:0] set_val_ext;
  logic [PMAX-1:0] clr_val_ext;
  logic [XN-1:0]   would_overflow;
  logic [XN-1:0]   underflow;
  logic [XN-1:0]   count_nz;
  logic            set_accept;

  assign set_vec     = VW'(set_idx);
  assign clr_vec     = VW'(clr_idx);
  assign set_val_ext = PMAX'(set_valid);
  assign clr_val_ext = PMAX'(clr_valid);

  // Register 0 is hardwired unlocked; out-of-range indices match no cell.
  assign would_overflow[0] = 1'b0;
  assign underflow[0]      = 1'b0;
  assign count_nz[0]       = 1'b0;

  for (genvar i = 1; i < XN; i++) begin : g_cell
    logic [IW-1:0] inc_req;
    logic [IW-1:0] dec_req;
    assign inc_req = IW'(popcount_match(set_vec, set_val_ext, WMAX'(i), NSET, XWDT));
    assign dec_req = IW'(popcount_match(clr_vec, clr_val_ext, WMAX'(i), NCLR, XWDT));

    rlock_cell #(.CWDT(CWDT), .IW(IW)) u_cell (
      .clk            (clk),
      .rst            (rst),
      .flush          (flush),
      .set_accept     (set_accept),
      .inc            (inc_req),
      .dec_req        (dec_req),
      .count_nz       (count_nz[i]),
      .would_overflow (would_overflow[i]),
      .underflow      (underflow[i])
    );
  end

  // Handshake: a set group moves on an edge where set_valid is high and set_ready
  // is high; the group is all-or-nothing and is held by the requester otherwise.
  // During flush set_ready is forced high but the sets are discarded.
  assign set_ready  = flush | ~(|would_overflow);
  assign set_accept = set_ready & ~flush;

  assign rlocks = count_nz;

  always_ff @(posedge clk) begin
    if (rst)                 err_underflow <= 1'b0;
    else if (|underflow)     err_underflow <= 1'b1;
    else if (err_clear)      err_underflow <= 1'b0;
  end

endmodule

// File: tb/tb_rlock_scoreboard.sv
// Directed bench for rlock_scoreboard: each task drives one scenario and
// checks hand-computed expectations inline.
module tb_rlock_scoreboard;

  localparam int XWDT = 6;
  localparam int XN   = 64;

  logic            clk;
  logic            rst;
  logic [1:0]      set_valid;
  logic [11:0]     set_idx;
  logic            set_ready;
  logic [1:0]      clr_valid;
  logic [11:0]     clr_idx;
  logic            flush;
  logic [XN-1:0]   rlocks;
  logic            err_underflow;
  logic            err_clear;

  int checks = 0;
  int errors = 0;

  rlock_scoreboard dut (
    .clk           (clk),
    .rst           (rst),
    .set_valid     (set_valid),
    .set_idx       (set_idx),
    .set_ready     (set_ready),
    .clr_valid     (clr_valid),
    .clr_idx       (clr_idx),
    .flush         (flush),
    .rlocks        (rlocks),
    .err_underflow (err_underflow),
    .err_clear     (err_clear)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [XN-1:0] bit_of(input int i);
    logic [XN-1:0] one;
    one = 1;
    return one << i;
  endfunction

  task automatic drive(input logic [1:0] sv, input int s0, input int s1,
                       input logic [1:0] cv, input int c0, input int c1);
    set_valid = sv;
    set_idx   = {6'(s1), 6'(s0)};
    clr_valid = cv;
    clr_idx   = {6'(c1), 6'(c0)};
  endtask

  task automatic idle();
    drive(2'b00, 0, 0, 2'b00, 0, 0);
    flush     = 1'b0;
    err_clear = 1'b0;
  endtask

  // Apply current inputs for one edge, then return inputs to idle.
  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    drive(2'b11, 3, 4, 2'b00, 0, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle();
    checks++;
    if (rlocks !== '0) begin
      errors++; $display("FAIL reset_rlocks: got %h want 0", rlocks);
    end
    checks++;
    if (set_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready: got %b want 1", set_ready);
    end
    checks++;
    if (err_underflow !== 1'b0) begin
      errors++; $display("FAIL reset_err: got %b want 0", err_underflow);
    end
  endtask

  task automatic test_dual_set();
    drive(2'b11, 5, 5, 2'b00, 0, 0); tick();
    checks++;
    if (rlocks !== bit_of(5)) begin
      errors++; $display("FAIL dual_set: got %h want %h", rlocks, bit_of(5));
    end
    drive(2'b00, 0, 0, 2'b11, 5, 5); tick();
    checks++;
    if (rlocks !== '0) begin
      errors++; $display("FAIL dual_clear: got %h want 0", rlocks);
    end
    drive(2'b11, 5, 5, 2'b00, 0, 0); tick();
    drive(2'b00, 0, 0, 2'b01, 5, 0); tick();
    checks++;
    if (rlocks !== bit_of(5)) begin
      errors++; $display("FAIL single_clear_of_two: got %h want %h", rlocks, bit_of(5));
    end
    drive(2'b00, 0, 0, 2'b10, 0, 5); tick();
    checks++;
    if (rlocks !== '0 || err_underflow !== 1'b0) begin
      errors++; $display("FAIL last_clear: got rlocks %h err %b want 0 0", rlocks, err_underflow);
    end
  endtask

  task automatic test_saturation();
    for (int k = 0; k < 3; k++) begin
      drive(2'b11, 7, 7, 2'b00, 0, 0); tick();
    end
    drive(2'b11, 7, 0, 2'b00, 0, 0); tick();
    checks++;
    if (rlocks !== bit_of(7)) begin
      errors++; $display("FAIL sat_count7: got %h want %h", rlocks, bit_of(7));
    end
    drive(2'b11, 7, 9, 2'b01, 7, 0);
    #1;
    checks++;
    if (set_ready !== 1'b0) begin
      errors++; $display("FAIL sat_backpressure: got %b want 0", set_ready);
    end
    tick();
    checks++;
    if (rlocks !== bit_of(7)) begin
      errors++; $display("FAIL sat_reject_9: got %h want %h", rlocks, bit_of(7));
    end
    drive(2'b11, 7, 9, 2'b00, 0, 0);
    #1;
    checks++;
    if (set_ready !== 1'b1) begin
      errors++; $display("FAIL sat_retry_ready: got %b want 1", set_ready);
    end
    tick();
    checks++;
    if (rlocks !== (bit_of(7) | bit_of(9))) begin
      errors++; $display("FAIL sat_retry: got %h want %h", rlocks, bit_of(7) | bit_of(9));
    end
    for (int k = 0; k < 3; k++) begin
      drive(2'b00, 0, 0, 2'b11, 7, 7); tick();
    end
    drive(2'b00, 0, 0, 2'b11, 7, 9); tick();
    checks++;
    if (rlocks !== '0 || err_underflow !== 1'b0) begin
      errors++; $display("FAIL sat_drain: got rlocks %h err %b want 0 0", rlocks, err_underflow);
    end
  endtask

  task automatic test_same_cycle();
    drive(2'b01, 2, 0, 2'b00, 0, 0); tick();
    drive(2'b01, 2, 0, 2'b01, 2, 0); tick();
    checks++;
    if (rlocks !== bit_of(2) || err_underflow !== 1'b0) begin
      errors++; $display("FAIL setclr_count1: got rlocks %h err %b want %h 0", rlocks, err_underflow, bit_of(2));
    end
    drive(2'b10, 0, 8, 2'b01, 8, 0); tick();
    checks++;
    if (rlocks !== (bit_of(2) | bit_of(8)) || err_underflow !== 1'b1) begin
      errors++; $display("FAIL setclr_count0: got rlocks %h err %b want %h 1", rlocks, err_underflow, bit_of(2) | bit_of(8));
    end
    drive(2'b00, 0, 0, 2'b11, 2, 8); tick();
    err_clear = 1'b1; tick();
    checks++;
    if (rlocks !== '0 || err_underflow !== 1'b0) begin
      errors++; $display("FAIL setclr_cleanup: got rlocks %h err %b want 0 0", rlocks, err_underflow);
    end
  endtask

  task automatic test_underflow();
    drive(2'b00, 0, 0, 2'b01, 10, 0); tick();
    checks++;
    if (err_underflow !== 1'b1 || rlocks[10] !== 1'b0) begin
      errors++; $display("FAIL underflow_set: got err %b lock10 %b want 1 0", err_underflow, rlocks[10]);
    end
    err_clear = 1'b1; tick();
    checks++;
    if (err_underflow !== 1'b0) begin
      errors++; $display("FAIL err_clear: got %b want 0", err_underflow);
    end
    drive(2'b00, 0, 0, 2'b10, 0, 10);
    err_clear = 1'b1; tick();
    checks++;
    if (err_underflow !== 1'b1) begin
      errors++; $display("FAIL underflow_wins: got %b want 1", err_underflow);
    end
    err_clear = 1'b1; tick();
    drive(2'b00, 0, 0, 2'b11, 0, 0); tick();
    checks++;
    if (err_underflow !== 1'b0) begin
      errors++; $display("FAIL idx0_clear_no_err: got %b want 0", err_underflow);
    end
  endtask

  task automatic test_flush_idx0();
    drive(2'b11, 1, 63, 2'b00, 0, 0); tick();
    drive(2'b11, 0, 0, 2'b00, 0, 0); tick();
    checks++;
    if (rlocks !== (bit_of(1) | bit_of(63))) begin
      errors++; $display("FAIL idx0_ignored: got %h want %h", rlocks, bit_of(1) | bit_of(63));
    end
    for (int k = 0; k < 3; k++) begin
      drive(2'b11, 7, 7, 2'b00, 0, 0); tick();
    end
    drive(2'b01, 7, 0, 2'b01, 11, 0); tick();
    drive(2'b11, 7, 12, 2'b01, 1, 0);
    flush = 1'b1;
    #1;
    checks++;
    if (set_ready !== 1'b1) begin
      errors++; $display("FAIL flush_ready: got %b want 1", set_ready);
    end
    tick();
    checks++;
    if (rlocks !== '0 || err_underflow !== 1'b1) begin
      errors++; $display("FAIL flush_clear: got rlocks %h err %b want 0 1", rlocks, err_underflow);
    end
    drive(2'b01, 12, 0, 2'b00, 0, 0); tick();
    checks++;
    if (rlocks !== bit_of(12)) begin
      errors++; $display("FAIL post_flush_set: got %h want %h", rlocks, bit_of(12));
    end
  endtask

  initial begin
    test_reset();
    test_dual_set();
    test_saturation();
    test_same_cycle();
    test_underflow();
    test_flush_idx0();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
